// File: rtl/ysyx_24080014_pkg.sv
// Shared types, CSR addresses and writeback helpers for the commit sequencer.
package ysyx_24080014_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned CSR_AW   = 12;
    localparam int unsigned CTL_W    = 2;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        MEM        = 3'd1,
        WB         = 3'd2,
        TRAP_EPC   = 3'd3,
        TRAP_CAUSE = 3'd4,
        ABORT      = 3'd5
    } state_e;

    // Machine-mode CSR addresses
    localparam logic [CSR_AW-1:0] CSR_MSTATUS = 12'h300;
    localparam logic [CSR_AW-1:0] CSR_MTVEC   = 12'h305;
    localparam logic [CSR_AW-1:0] CSR_MEPC    = 12'h341;
    localparam logic [CSR_AW-1:0] CSR_MCAUSE  = 12'h342;

    // csrs_ctl encodings (code 3 is folded to NONE on accept)
    localparam logic [CTL_W-1:0] CSRS_NONE  = 2'd0;
    localparam logic [CTL_W-1:0] CSRS_ECALL = 2'd1;
    localparam logic [CTL_W-1:0] CSRS_MRET  = 2'd2;

    // Instruction fields latched on accept
    typedef struct packed {
        logic              reg_wr;
        logic              load;
        logic              store;
        logic [CTL_W-1:0]  csrs_ctl;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   rd_data;
        logic [CSR_AW-1:0] csr_waddr;
        logic [XLEN-1:0]   csr_wdata;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   a5_val;
        logic [XLEN-1:0]   mtvec;
        logic [XLEN-1:0]   mepc;
    } instr_t;

    // Register-file / PC update produced by a WB cycle
    typedef struct packed {
        logic              gpr_wen;
        logic [REG_AW-1:0] gpr_waddr;
        logic [XLEN-1:0]   gpr_wdata;
        logic              csr_wen;
        logic [CSR_AW-1:0] csr_waddr;
        logic [XLEN-1:0]   csr_wdata;
        logic [XLEN-1:0]   next_pc;
    } wb_out_t;

    // Only the four implemented CSRs accept writes
    function automatic logic csr_writable(input logic [CSR_AW-1:0] addr);
        return (addr == CSR_MSTATUS) || (addr == CSR_MTVEC) ||
               (addr == CSR_MEPC)    || (addr == CSR_MCAUSE);
    endfunction

    // Writeback update for a non-trapping instruction
    function automatic wb_out_t wb_compute(input instr_t ins, input logic [XLEN-1:0] rdata);
        wb_out_t o;
        o.gpr_wen   = ins.reg_wr & ~ins.store & (ins.rd != REG_AW'(0));
        o.gpr_waddr = ins.rd;
        o.gpr_wdata = ins.load ? rdata : ins.rd_data;
        o.csr_wen   = (ins.csrs_ctl != CSRS_ECALL) & csr_writable(ins.csr_waddr);
        o.csr_waddr = ins.csr_waddr;
        o.csr_wdata = ins.csr_wdata;
        o.next_pc   = (ins.csrs_ctl == CSRS_MRET) ? ins.mepc : (ins.pc + XLEN'(4));
        return o;
    endfunction

endpackage

// File: rtl/ysyx_24080014_wb_ctrl_mem_timer.sv
// Clear/enable cycle counter flagging a memory access that has waited too long.
module ysyx_24080014_mem_timer #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired_c
);

    localparam int unsigned CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

    logic [CW-1:0] r_cnt;

    // Count enabled cycles; hold once the limit is reached
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_expired_c) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_expired_c = (r_cnt == CW'(MEM_TIMEOUT));

endmodule

// File: rtl/ysyx_24080014_wb_ctrl.sv
// Single-issue writeback/commit sequencer in front of the GPR/CSR register file.
module ysyx_24080014_wb_ctrl
    import ysyx_24080014_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter logic [31:0] RESET_PC    = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        reg_wr,
    input  logic        load,
    input  logic        store,
    input  logic [1:0]  csrs_ctl,
    input  logic [4:0]  rd,
    input  logic [31:0] rd_data,
    input  logic [11:0] csr_waddr,
    input  logic [31:0] csr_wdata,
    input  logic [31:0] pc,
    input  logic [31:0] a5_val,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    output logic        mem_req,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        gpr_wen,
    output logic [4:0]  gpr_waddr,
    output logic [31:0] gpr_wdata,
    output logic        csr_wen,
    output logic [11:0] csr_waddr_o,
    output logic [31:0] csr_wdata_o,
    output logic        pc_wen,
    output logic [31:0] next_pc,
    output logic        commit,
    output logic        mem_err
);

    state_e            r_state;
    instr_t            r_instr;
    logic              r_in_ready;
    logic              r_mem_req;
    logic              r_gpr_wen;
    logic [REG_AW-1:0] r_gpr_waddr;
    logic [XLEN-1:0]   r_gpr_wdata;
    logic              r_csr_wen;
    logic [CSR_AW-1:0] r_csr_waddr;
    logic [XLEN-1:0]   r_csr_wdata;
    logic              r_pc_wen;
    logic [XLEN-1:0]   r_next_pc;
    logic              r_commit;
    logic              r_mem_err;

    instr_t            w_in;
    wb_out_t           w_wb_in;
    wb_out_t           w_wb_mem;
    logic              w_in_mem;
    logic              w_tmr_en;
    logic              w_expired;

    // Incoming fields; reserved csrs_ctl code behaves as NONE
    always_comb begin
        w_in           = '0;
        w_in.reg_wr    = reg_wr;
        w_in.load      = load;
        w_in.store     = store;
        w_in.csrs_ctl  = (csrs_ctl == 2'd3) ? CSRS_NONE : csrs_ctl;
        w_in.rd        = rd;
        w_in.rd_data   = rd_data;
        w_in.csr_waddr = csr_waddr;
        w_in.csr_wdata = csr_wdata;
        w_in.pc        = pc;
        w_in.a5_val    = a5_val;
        w_in.mtvec     = mtvec;
        w_in.mepc      = mepc;
    end

    assign w_in_mem = load | store;
    assign w_wb_in  = wb_compute(w_in, XLEN'(0));
    assign w_wb_mem = wb_compute(r_instr, mem_rdata);
    assign w_tmr_en = (r_state == MEM);

    ysyx_24080014_mem_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_mem_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (!w_tmr_en),
        .i_en        (w_tmr_en),
        .o_expired_c (w_expired)
    );

    // Sequencer: state and every output register, strobes default low each cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_instr     <= '0;
            r_in_ready  <= 1'b1;
            r_mem_req   <= 1'b0;
            r_gpr_wen   <= 1'b0;
            r_gpr_waddr <= '0;
            r_gpr_wdata <= '0;
            r_csr_wen   <= 1'b0;
            r_csr_waddr <= '0;
            r_csr_wdata <= '0;
            r_pc_wen    <= 1'b0;
            r_next_pc   <= RESET_PC;
            r_commit    <= 1'b0;
            r_mem_err   <= 1'b0;
        end else begin
            r_gpr_wen <= 1'b0;
            r_csr_wen <= 1'b0;
            r_pc_wen  <= 1'b0;
            r_commit  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_instr    <= w_in;
                        r_in_ready <= 1'b0;
                        if (w_in_mem) begin
                            r_state   <= MEM;
                            r_mem_req <= 1'b1;
                        end else if (w_in.csrs_ctl == CSRS_ECALL) begin
                            r_state     <= TRAP_EPC;
                            r_csr_wen   <= 1'b1;
                            r_csr_waddr <= CSR_MEPC;
                            r_csr_wdata <= w_in.pc;
                        end else begin
                            r_state     <= WB;
                            r_gpr_wen   <= w_wb_in.gpr_wen;
                            r_gpr_waddr <= w_wb_in.gpr_waddr;
                            r_gpr_wdata <= w_wb_in.gpr_wdata;
                            r_csr_wen   <= w_wb_in.csr_wen;
                            r_csr_waddr <= w_wb_in.csr_waddr;
                            r_csr_wdata <= w_wb_in.csr_wdata;
                            r_pc_wen    <= 1'b1;
                            r_next_pc   <= w_wb_in.next_pc;
                            r_commit    <= 1'b1;
                        end
                    end
                end
                MEM: begin
                    // Completion takes priority over an expiring timer
                    if (mem_ready) begin
                        r_state     <= WB;
                        r_mem_req   <= 1'b0;
                        r_gpr_wen   <= w_wb_mem.gpr_wen;
                        r_gpr_waddr <= w_wb_mem.gpr_waddr;
                        r_gpr_wdata <= w_wb_mem.gpr_wdata;
                        r_csr_wen   <= w_wb_mem.csr_wen;
                        r_csr_waddr <= w_wb_mem.csr_waddr;
                        r_csr_wdata <= w_wb_mem.csr_wdata;
                        r_pc_wen    <= 1'b1;
                        r_next_pc   <= w_wb_mem.next_pc;
                        r_commit    <= 1'b1;
                    end else if (w_expired) begin
                        r_state   <= ABORT;
                        r_mem_req <= 1'b0;
                        r_mem_err <= 1'b1;
                        r_pc_wen  <= 1'b1;
                        r_next_pc <= r_instr.pc + XLEN'(4);
                        r_commit  <= 1'b1;
                    end
                end
                TRAP_EPC: begin
                    r_state     <= TRAP_CAUSE;
                    r_csr_wen   <= 1'b1;
                    r_csr_waddr <= CSR_MCAUSE;
                    r_csr_wdata <= r_instr.a5_val;
                    r_pc_wen    <= 1'b1;
                    r_next_pc   <= r_instr.mtvec;
                    r_commit    <= 1'b1;
                end
                WB, TRAP_CAUSE, ABORT: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b1;
                end
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b1;
                    r_mem_req  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign mem_req     = r_mem_req;
    assign gpr_wen     = r_gpr_wen;
    assign gpr_waddr   = r_gpr_waddr;
    assign gpr_wdata   = r_gpr_wdata;
    assign csr_wen     = r_csr_wen;
    assign csr_waddr_o = r_csr_waddr;
    assign csr_wdata_o = r_csr_wdata;
    assign pc_wen      = r_pc_wen;
    assign next_pc     = r_next_pc;
    assign commit      = r_commit;
    assign mem_err     = r_mem_err;

endmodule

// File: tb/tb_ysyx_24080014_wb_ctrl.sv
// Directed self-checking bench for the writeback/commit sequencer (MEM_TIMEOUT = 4).
module tb_ysyx_24080014_wb_ctrl;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, reg_wr, load, store;
    logic [1:0]  csrs_ctl;
    logic [4:0]  rd;
    logic [31:0] rd_data, csr_wdata, pc, a5_val, mtvec, mepc, mem_rdata;
    logic [11:0] csr_waddr, csr_waddr_o;
    logic        mem_req, mem_ready, gpr_wen, csr_wen, pc_wen, commit, mem_err;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata, csr_wdata_o, next_pc;

    int n_cmp = 0;
    int n_bad = 0;

    ysyx_24080014_wb_ctrl #(.MEM_TIMEOUT(4), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .reg_wr(reg_wr), .load(load), .store(store), .csrs_ctl(csrs_ctl),
        .rd(rd), .rd_data(rd_data), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .pc(pc), .a5_val(a5_val), .mtvec(mtvec), .mepc(mepc),
        .mem_req(mem_req), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
        .csr_wen(csr_wen), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
        .pc_wen(pc_wen), .next_pc(next_pc), .commit(commit), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; reg_wr = 0; load = 0; store = 0; csrs_ctl = 0;
        rd = 0; rd_data = 0; csr_waddr = 0; csr_wdata = 0; pc = 0;
        a5_val = 0; mtvec = 0; mepc = 0; mem_ready = 0; mem_rdata = 0;
    endtask

    // Present current fields for one edge, then drop in_valid
    task automatic accept();
        in_valid = 1;
        tick();
        in_valid = 0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        #12;
        check("rst next_pc", next_pc, RST_PC);
        check("rst strobes", {28'd0, mem_req, gpr_wen, csr_wen, commit}, 32'd0);
        check("rst pc_wen/mem_err", {30'd0, pc_wen, mem_err}, 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);
        tick();
        rst_n = 1;
        tick();

        // ALU writeback
        reg_wr = 1; rd = 5; rd_data = 32'h1234; pc = 32'h8000_0000;
        accept();
        idle_inputs();
        check("alu gpr_wen", 32'(gpr_wen), 32'd1);
        check("alu waddr", 32'(gpr_waddr), 32'd5);
        check("alu wdata", gpr_wdata, 32'h1234);
        check("alu next_pc", next_pc, 32'h8000_0004);
        check("alu commit/pc_wen", {30'd0, commit, pc_wen}, 32'd3);
        check("alu csr_wen", 32'(csr_wen), 32'd0);
        check("alu in_ready busy", 32'(in_ready), 32'd0);
        tick();
        check("alu in_ready after", 32'(in_ready), 32'd1);
        check("alu commit pulse", 32'(commit), 32'd0);

        // Load, mem_ready in 3rd MEM cycle
        reg_wr = 1; load = 1; rd = 7; rd_data = 32'h5555; pc = 32'h8000_0010;
        accept();
        idle_inputs();
        check("ld mem_req c1", 32'(mem_req), 32'd1);
        check("ld in_ready c1", 32'(in_ready), 32'd0);
        tick();
        check("ld mem_req c2", 32'(mem_req), 32'd1);
        check("ld commit c2", 32'(commit), 32'd0);
        tick();
        check("ld mem_req c3", 32'(mem_req), 32'd1);
        mem_ready = 1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ready = 0; mem_rdata = 0;
        check("ld mem_req off", 32'(mem_req), 32'd0);
        check("ld gpr_wen", 32'(gpr_wen), 32'd1);
        check("ld waddr", 32'(gpr_waddr), 32'd7);
        check("ld wdata", gpr_wdata, 32'hDEAD_BEEF);
        check("ld next_pc", next_pc, 32'h8000_0014);
        check("ld commit", 32'(commit), 32'd1);
        check("ld in_ready wb", 32'(in_ready), 32'd0);
        tick();
        check("ld in_ready after", 32'(in_ready), 32'd1);

        // ecall: fields change right after accept to prove latching
        reg_wr = 1; rd = 3; csrs_ctl = 1; pc = 32'h8000_0100; a5_val = 11;
        mtvec = 32'h8000_0400;
        accept();
        idle_inputs();
        a5_val = 32'd99; mtvec = 32'h1111_0000;
        check("ecall epc csr_wen", 32'(csr_wen), 32'd1);
        check("ecall epc addr", 32'(csr_waddr_o), 32'h341);
        check("ecall epc data", csr_wdata_o, 32'h8000_0100);
        check("ecall epc no commit/gpr", {30'd0, commit, gpr_wen}, 32'd0);
        tick();
        check("ecall cause csr_wen", 32'(csr_wen), 32'd1);
        check("ecall cause addr", 32'(csr_waddr_o), 32'h342);
        check("ecall cause data", csr_wdata_o, 32'd11);
        check("ecall next_pc", next_pc, 32'h8000_0400);
        check("ecall commit/pc_wen", {30'd0, commit, pc_wen}, 32'd3);
        check("ecall gpr_wen", 32'(gpr_wen), 32'd0);
        tick();
        check("ecall idle", {30'd0, in_ready, csr_wen}, 32'd2);
        idle_inputs();

        // mret
        csrs_ctl = 2; mepc = 32'h8000_0104; pc = 32'h8000_0200;
        accept();
        idle_inputs();
        check("mret next_pc", next_pc, 32'h8000_0104);
        check("mret commit", 32'(commit), 32'd1);
        check("mret gpr_wen", 32'(gpr_wen), 32'd0);
        tick();

        // CSR write to mtvec; reserved ctl code 3 acts as none
        csrs_ctl = 3; csr_waddr = 12'h305; csr_wdata = 32'h8000_0800; pc = 32'h8000_0300;
        accept();
        idle_inputs();
        check("csr wen", 32'(csr_wen), 32'd1);
        check("csr addr", 32'(csr_waddr_o), 32'h305);
        check("csr data", csr_wdata_o, 32'h8000_0800);
        check("csr ctl3 next_pc", next_pc, 32'h8000_0304);
        tick();

        // Unimplemented CSR address ignored
        csr_waddr = 12'h123; csr_wdata = 32'hFFFF_FFFF; pc = 32'h8000_0400;
        accept();
        idle_inputs();
        check("csr bad addr wen", 32'(csr_wen), 32'd0);
        check("csr bad addr commit", 32'(commit), 32'd1);
        tick();

        // ALU with rd=0, pc wrap
        reg_wr = 1; rd = 0; rd_data = 32'h77; pc = 32'hFFFF_FFFC;
        accept();
        idle_inputs();
        check("rd0 gpr_wen", 32'(gpr_wen), 32'd0);
        check("rd0 commit", 32'(commit), 32'd1);
        check("wrap next_pc", next_pc, 32'h0000_0000);
        tick();

        // Store, ready on first MEM cycle, reg_wr ignored
        reg_wr = 1; store = 1; rd = 9; pc = 32'h8000_0500;
        accept();
        idle_inputs();
        mem_ready = 1;
        tick();
        mem_ready = 0;
        check("st gpr_wen", 32'(gpr_wen), 32'd0);
        check("st commit", 32'(commit), 32'd1);
        check("st next_pc", next_pc, 32'h8000_0504);
        tick();

        // mem_ready in the same cycle the timer expires (5th MEM cycle)
        store = 1; pc = 32'h8000_0600;
        accept();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            check("race mem_req", 32'(mem_req), 32'd1);
            tick();
        end
        check("race mem_req c5", 32'(mem_req), 32'd1);
        mem_ready = 1;
        tick();
        mem_ready = 0;
        check("race commit", 32'(commit), 32'd1);
        check("race mem_err", 32'(mem_err), 32'd0);
        check("race next_pc", next_pc, 32'h8000_0604);
        tick();

        // Timeout: store never completes
        store = 1; pc = 32'h8000_0700; csr_waddr = 12'h300; csr_wdata = 32'h8;
        accept();
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            check("to mem_req", 32'(mem_req), 32'd1);
            check("to no commit", 32'(commit), 32'd0);
            tick();
        end
        check("to mem_req off", 32'(mem_req), 32'd0);
        check("to mem_err", 32'(mem_err), 32'd1);
        check("to commit/pc_wen", {30'd0, commit, pc_wen}, 32'd3);
        check("to next_pc", next_pc, 32'h8000_0704);
        check("to no writes", {30'd0, gpr_wen, csr_wen}, 32'd0);
        tick();
        check("to in_ready", 32'(in_ready), 32'd1);
        tick();
        check("to mem_err sticky", 32'(mem_err), 32'd1);

        // Reset in the middle of a load
        reg_wr = 1; load = 1; rd = 4; pc = 32'h8000_0800;
        accept();
        idle_inputs();
        tick();
        check("rst-mid mem_req before", 32'(mem_req), 32'd1);
        #2;
        rst_n = 0;
        #1;
        check("rst-mid mem_req", 32'(mem_req), 32'd0);
        check("rst-mid mem_err", 32'(mem_err), 32'd0);
        check("rst-mid next_pc", next_pc, RST_PC);
        tick();
        rst_n = 1;
        mem_ready = 1; mem_rdata = 32'hBAD0_BAD0;
        tick();
        mem_ready = 0;
        check("rst-mid in_ready", 32'(in_ready), 32'd1);
        check("rst-mid no commit", {29'd0, commit, gpr_wen, mem_req}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
